seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the multi-digit common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_hex_decoder.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding and
// active-low glyph constants in {g,f,e,d,c,b,a} bit order.
package seg_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph lookup; lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      4'hE: seg_n = GLYPH_E;
      4'hF: seg_n = GLYPH_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for a common-anode multi-digit 7-segment display.
// Each digit slot starts with a blanking guard, then drives one anode low.
// Display data is double-buffered: LOAD fills the pending buffer, and the
// active buffer only changes on scan start or at a frame wrap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | display dark, counters held at zero, waiting for EN
//   ST_SCAN | walking digits; cnt times the slot, digit selects the anode
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA_IN,
  input  logic [DIGITS-1:0]     DP_IN,
  output logic [6:0]            SEG_N,
  output logic                  DP_N,
  output logic [DIGITS-1:0]     AN_N,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DIG_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DIG_W-1:0]    digit, digit_nxt;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic                transfer;
  logic [3:0]          cur_nibble;
  logic [6:0]          cur_seg;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;
  logic                frame_nxt;

  assign cur_nibble = act_data[{digit, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .seg_n  (cur_seg)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, slot timing, buffer transfer and next output values.
  // Outputs are computed from the current cnt/digit, so they trail them by one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    digit_nxt = '0;
    transfer  = 1'b0;
    frame_nxt = 1'b0;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    an_nxt    = '1;
    case (state)
      ST_IDLE: begin
        if (EN) begin
          state_nxt = ST_SCAN;
          transfer  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!EN) begin
          state_nxt = ST_IDLE;
        end else begin
          if (cnt == CNT_LAST) begin
            if (digit == DIG_LAST) begin
              transfer  = 1'b1;
              frame_nxt = 1'b1;
            end else begin
              digit_nxt = digit + 1'b1;
            end
          end else begin
            cnt_nxt   = cnt + 1'b1;
            digit_nxt = digit;
          end
          if (cnt >= CNT_BLANK) begin
            an_nxt  = ~(DIGITS'(1) << digit);
            seg_nxt = cur_seg;
            dp_nxt  = ~act_dp[digit];
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slot counter and digit index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      digit <= '0;
    end else begin
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
    end
  end

  // Pending/active buffers; a LOAD coinciding with a transfer bypasses straight to active.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (LOAD) begin
        pend_data <= DATA_IN;
        pend_dp   <= DP_IN;
      end
      if (transfer) begin
        act_data <= LOAD ? DATA_IN : pend_data;
        act_dp   <= LOAD ? DP_IN   : pend_dp;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG_N      <= SEG_OFF;
      DP_N       <= 1'b1;
      AN_N       <= '1;
      FRAME_DONE <= 1'b0;
    end else begin
      SEG_N      <= seg_nxt;
      DP_N       <= dp_nxt;
      AN_N       <= an_nxt;
      FRAME_DONE <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Expected digit slots are queued by the tests and checked by a slot monitor.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int SLOT_ON   = SCAN_DIV - BLANK_CYC;
  localparam int FIRST_LAT = BLANK_CYC + 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic [3:0]  DP_IN = '0;
  logic [6:0]  SEG_N;
  logic        DP_N;
  logic [3:0]  AN_N;
  logic        FRAME_DONE;

  int    total = 0;
  int    bad = 0;
  bit    mon_on = 1'b0;
  slot_t exp_q[$];

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .LOAD       (LOAD),
    .DATA_IN    (DATA_IN),
    .DP_IN      (DP_IN),
    .SEG_N      (SEG_N),
    .DP_N       (DP_N),
    .AN_N       (AN_N),
    .FRAME_DONE (FRAME_DONE)
  );

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
    slot_t s;
    for (int i = 0; i < DIGITS; i++) begin
      s.an  = ~(4'b0001 << i);
      s.seg = glyph(d[4*i +: 4]);
      s.dp  = ~dp[i];
      exp_q.push_back(s);
    end
  endtask

  // Slot monitor: one digit slot = a run of cycles with an anode low.
  initial begin
    bit         in_slot, have_prev, hold_bad, dark_bad;
    int         run_len, gap_len, gap_at_start;
    logic [3:0] s_an;
    logic [6:0] s_seg;
    logic       s_dp;
    slot_t      e;
    in_slot = 0; have_prev = 0; hold_bad = 0; dark_bad = 0;
    run_len = 0; gap_len = 0; gap_at_start = 0;
    s_an = '1; s_seg = '1; s_dp = 1'b1;
    forever begin
      @(negedge CLK);
      if (!mon_on) begin
        in_slot = 0; have_prev = 0; gap_len = 0; dark_bad = 0;
      end else if (AN_N === 4'hF) begin
        if (in_slot) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL slot_unexpected: got an=%b seg=%b, required no slot", s_an, s_seg);
          end else begin
            e = exp_q.pop_front();
            total++;
            if (s_an !== e.an) begin
              bad++; $display("FAIL slot_an: got %b, required %b", s_an, e.an);
            end
            total++;
            if (s_seg !== e.seg) begin
              bad++; $display("FAIL slot_seg an=%b: got %b, required %b", e.an, s_seg, e.seg);
            end
            total++;
            if (s_dp !== e.dp) begin
              bad++; $display("FAIL slot_dp an=%b: got %b, required %b", e.an, s_dp, e.dp);
            end
            total++;
            if (run_len != SLOT_ON) begin
              bad++; $display("FAIL slot_len an=%b: got %0d, required %0d", e.an, run_len, SLOT_ON);
            end
            total++;
            if (hold_bad) begin
              bad++; $display("FAIL slot_stable an=%b: got outputs changing, required constant", e.an);
            end
            if (have_prev) begin
              total++;
              if (gap_at_start != BLANK_CYC) begin
                bad++; $display("FAIL slot_gap an=%b: got %0d, required %0d", e.an, gap_at_start, BLANK_CYC);
              end
            end
            total++;
            if (dark_bad) begin
              bad++; $display("FAIL dark_outputs: got segments lit while dark, required 7f/1");
            end
          end
          in_slot = 0; have_prev = 1; gap_len = 0; dark_bad = 0;
        end
        gap_len++;
        if (SEG_N !== 7'h7F || DP_N !== 1'b1) dark_bad = 1;
      end else begin
        if (!in_slot) begin
          in_slot = 1; run_len = 0; hold_bad = 0;
          s_an = AN_N; s_seg = SEG_N; s_dp = DP_N;
          gap_at_start = gap_len;
        end
        run_len++;
        if (AN_N !== s_an || SEG_N !== s_seg || DP_N !== s_dp) hold_bad = 1;
      end
    end
  end

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #2;
    total++; if (SEG_N !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h, required 7f", SEG_N); end
    total++; if (DP_N !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b, required 1", DP_N); end
    total++; if (AN_N !== 4'hF) begin bad++; $display("FAIL reset_an: got %b, required 1111", AN_N); end
    total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b, required 0", FRAME_DONE); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (AN_N !== 4'hF) begin bad++; $display("FAIL reset_hold_an: got %b, required 1111", AN_N); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic test_scan_order();
    int n;
    @(posedge CLK);
    #1 LOAD = 1'b1; DATA_IN = 16'h1234; DP_IN = 4'b0101;
    @(posedge CLK);
    #1 LOAD = 1'b0; DATA_IN = '0; DP_IN = '0;
    push_frame(16'h1234, 4'b0101);
    mon_on = 1'b1;
    EN = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); n++; @(negedge CLK);
    end while (AN_N === 4'hF && n < 20);
    total++;
    if (n != FIRST_LAT) begin bad++; $display("FAIL first_anode_latency: got %0d, required %0d", n, FIRST_LAT); end
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin @(negedge CLK); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_scan_order: got %0d slots left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_frame_done();
    int   n;
    logic fd1;
    logic [3:0] an3;
    push_frame(16'h1234, 4'b0101);
    push_frame(16'h1234, 4'b0101);
    n = 0;
    do begin @(negedge CLK); n++; end while (FRAME_DONE !== 1'b1 && n < 40);
    total++;
    if (FRAME_DONE !== 1'b1) begin bad++; $display("FAIL frame_done_seen: got %b, required 1", FRAME_DONE); end
    total++;
    if (AN_N !== 4'b0111) begin bad++; $display("FAIL frame_done_an: got %b, required 0111", AN_N); end
    n = 0; fd1 = 1'bx; an3 = 'x;
    do begin
      @(negedge CLK); n++;
      if (n == 1) fd1 = FRAME_DONE;
      if (n == 3) an3 = AN_N;
    end while (FRAME_DONE !== 1'b1 && n < 40);
    total++;
    if (fd1 !== 1'b0) begin bad++; $display("FAIL frame_done_width: got %b after 1 cycle, required 0", fd1); end
    total++;
    if (n != 32) begin bad++; $display("FAIL frame_done_period: got %0d, required 32", n); end
    total++;
    if (an3 !== 4'b1110) begin bad++; $display("FAIL wrap_to_digit0: got %b, required 1110", an3); end
  endtask

  task automatic test_midframe_load();
    int n;
    push_frame(16'h1234, 4'b0101);
    push_frame(16'hFFFF, 4'b0000);
    repeat (10) @(posedge CLK);
    #1 LOAD = 1'b1; DATA_IN = 16'hFFFF; DP_IN = 4'b0000;
    @(posedge CLK);
    #1 LOAD = 1'b0; DATA_IN = '0;
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin @(negedge CLK); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_midframe: got %0d slots left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    push_frame(16'hFFFF, 4'b0000);
    push_frame(16'h8888, 4'b0000);
    repeat (3) @(posedge CLK);
    #1 LOAD = 1'b1; DATA_IN = 16'h7777; DP_IN = 4'b1111;
    @(posedge CLK);
    #1 DATA_IN = 16'h8888; DP_IN = 4'b0000;
    @(posedge CLK);
    #1 LOAD = 1'b0; DATA_IN = '0;
  endtask

  task automatic test_wrap_bypass();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (FRAME_DONE !== 1'b1 && n < 40);
    total++;
    if (FRAME_DONE !== 1'b1) begin bad++; $display("FAIL bypass_sync: got %b, required 1", FRAME_DONE); end
    repeat (31) @(posedge CLK);
    #1 LOAD = 1'b1; DATA_IN = 16'hA5C3; DP_IN = 4'b1011;
    @(posedge CLK);
    #1 LOAD = 1'b0; DATA_IN = '0; DP_IN = '0;
    @(negedge CLK);
    total++;
    if (FRAME_DONE !== 1'b1) begin bad++; $display("FAIL bypass_on_wrap: got %b, required 1", FRAME_DONE); end
    push_frame(16'hA5C3, 4'b1011);
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin @(negedge CLK); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_bypass: got %0d slots left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_en_drop();
    int n;
    mon_on = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (AN_N !== 4'b1110) begin bad++; $display("FAIL en_drop_pre: got %b, required 1110", AN_N); end
    EN = 1'b0;
    @(negedge CLK);
    total++; if (AN_N !== 4'hF) begin bad++; $display("FAIL en_drop_an: got %b, required 1111", AN_N); end
    total++; if (SEG_N !== 7'h7F) begin bad++; $display("FAIL en_drop_seg: got %h, required 7f", SEG_N); end
    total++; if (DP_N !== 1'b1) begin bad++; $display("FAIL en_drop_dp: got %b, required 1", DP_N); end
    repeat (3) @(negedge CLK);
    total++; if (AN_N !== 4'hF) begin bad++; $display("FAIL en_off_hold: got %b, required 1111", AN_N); end
    EN = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); n++; @(negedge CLK);
    end while (AN_N === 4'hF && n < 20);
    total++; if (n != FIRST_LAT) begin bad++; $display("FAIL reenable_latency: got %0d, required %0d", n, FIRST_LAT); end
    total++; if (AN_N !== 4'b1110) begin bad++; $display("FAIL reenable_an: got %b, required 1110", AN_N); end
    total++; if (SEG_N !== glyph(4'h3)) begin bad++; $display("FAIL reenable_seg: got %b, required %b", SEG_N, glyph(4'h3)); end
    total++; if (DP_N !== 1'b0) begin bad++; $display("FAIL reenable_dp: got %b, required 0", DP_N); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    total++; if (AN_N !== 4'hF) begin bad++; $display("FAIL rst_mid_an: got %b, required 1111", AN_N); end
    total++; if (SEG_N !== 7'h7F) begin bad++; $display("FAIL rst_mid_seg: got %h, required 7f", SEG_N); end
    total++; if (DP_N !== 1'b1) begin bad++; $display("FAIL rst_mid_dp: got %b, required 1", DP_N); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); n++; @(negedge CLK);
    end while (AN_N === 4'hF && n < 20);
    total++; if (n != FIRST_LAT) begin bad++; $display("FAIL rst_resume_latency: got %0d, required %0d", n, FIRST_LAT); end
    total++; if (AN_N !== 4'b1110) begin bad++; $display("FAIL rst_resume_an: got %b, required 1110", AN_N); end
    total++; if (SEG_N !== glyph(4'h0)) begin bad++; $display("FAIL rst_cleared_seg: got %b, required %b", SEG_N, glyph(4'h0)); end
    total++; if (DP_N !== 1'b1) begin bad++; $display("FAIL rst_cleared_dp: got %b, required 1", DP_N); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_frame_done();
    test_midframe_load();
    test_back_to_back();
    test_wrap_bypass();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
